// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
//
// Multi-cycle WIDTH-bit adder. Each cycle it adds one CHUNK-bit slice of the
// latched operands. Within a slice, per-bit generate/propagate terms feed a
// flattened carry-lookahead network. The carry out of the slice is registered
// and becomes the carry into the next slice. The arithmetic is modulo
// 2^WIDTH. The (WIDTH+1)-bit result is presented as {cout, sum}, and ovf
// flags signed overflow.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   a, b and cin are valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum, cout and ovf hold a completed result
//   out_ready  consumer accepts the result
//   sum        registered WIDTH-bit sum
//   cout       carry out of the MSB
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module cla_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic [IDX_W-1:0] idx_reg;

    // Slice currently being added
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             last_slice;

    assign a_slice    = a_reg[idx_reg * CHUNK +: CHUNK];
    assign b_slice    = b_reg[idx_reg * CHUNK +: CHUNK];
    assign last_slice = (idx_reg == IDX_W'(N - 1));
    assign c[0]       = carry_reg;

    // ------------------------------------------------------------------
    // Per-bit generate/propagate and flattened lookahead carries.
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]c[0].
    // Each carry is a single sum of products over g, p and the slice
    // carry-in. No carry depends on another computed carry, so the
    // network stays two-level rather than a ripple chain.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            logic carry_bit;
            logic term;

            assign g[gi] = a_slice[gi] & b_slice[gi];
            assign p[gi] = a_slice[gi] ^ b_slice[gi];

            always_comb begin
                carry_bit = 1'b0;
                term      = 1'b0;
                // Term that carries the slice carry-in all the way up
                term = c[0];
                for (int k = 0; k <= gi; k++) begin
                    term = term & p[k];
                end
                carry_bit = term;
                // One product term per generating bit j <= gi
                for (int j = 0; j <= gi; j++) begin
                    term = g[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        term = term & p[k];
                    end
                    carry_bit = carry_bit | term;
                end
            end

            assign c[gi+1] = carry_bit;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Reset is asynchronous, so gate ready directly on rst
                // rather than waiting for the state register to clear.
                in_ready = ~rst;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Operands are captured here. The inputs are free
                        // to change while the slices are being worked off.
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                    end
                end
                CALC: begin
                    sum_reg[idx_reg * CHUNK +: CHUNK] <= p ^ c[CHUNK-1:0];
                    carry_reg <= c[CHUNK];
                    if (last_slice) begin
                        cout_reg <= c[CHUNK];
                        // Carry into the MSB is the carry into the top bit
                        // of the last slice.
                        ovf_reg  <= c[CHUNK-1] ^ c[CHUNK];
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    // DONE: result held stable until handed off
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_adder
//
// Self-checking bench. The main instance has WIDTH=32 and CHUNK=4. A second
// instance has WIDTH=32 and CHUNK=32, which gives a single-slice operation.
// The reference model is plain 33-bit integer addition plus a sign-based
// overflow rule.
// -----------------------------------------------------------------------------
module tb_cla_serial_adder;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, cout, ovf;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] a1, b1, sum1;
    logic        cin1, cout1, ovf1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_serial_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, cout, sum[31:0]}
    function automatic logic [33:0] ref_add(input logic [31:0] xa, input logic [31:0] xb,
                                            input logic xc);
        logic [32:0] full;
        logic        v;
        full = {1'b0, xa} + {1'b0, xb} + {32'd0, xc};
        // Overflow: both operands share a sign that the result does not
        v = (xa[31] == xb[31]) && (full[31] != xa[31]);
        return {v, full};
    endfunction

    // One full transaction on the CHUNK=4 instance.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                          input int hold, input string name,
                          output logic [31:0] rs, output logic rc, output logic ro);
        logic [33:0] exp;
        int          n;
        int          lat;
        exp = ref_add(xa, xb, xc);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: the block must have latched the operands already
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_sum"}, 64'(sum), 64'(exp[31:0]));
        check({name, "_cout"}, 64'(cout), 64'(exp[32]));
        check({name, "_ovf"}, 64'(ovf), 64'(exp[33]));
        rs = sum;
        rc = cout;
        ro = ovf;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_sum"}, 64'(sum), 64'(exp[31:0]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_release"}, 64'({out_valid, in_ready}), 64'b01);
        $display("[TB] %s a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d ovf=%0d lat=%0d",
                 name, xa, xb, xc, rs, rc, ro, lat);
    endtask

    initial begin
        logic [31:0] rs;
        logic        rc, ro;
        logic [33:0] exp;
        logic        seen;
        int          lat;

        vecs[0] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;  out_ready  = 1'b0;  a  = '0; b  = '0; cin  = 1'b0;
        in_valid1  = 1'b0;  out_ready1 = 1'b0;  a1 = '0; b1 = '0; cin1 = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_in_ready1", 64'(in_ready1), 64'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, $sformatf("vec%0d", i), rs, rc, ro);
            check($sformatf("vec%0d_tbl_sum", i), 64'(rs), 64'(vecs[i].sum));
            check($sformatf("vec%0d_tbl_flags", i), 64'({rc, ro}), 64'({vecs[i].cout, vecs[i].ovf}));
        end

        // ---------------- back-pressure with pending input ----------------
        @(negedge clk);
        a = 32'h12345678; b = 32'h87654321; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Keep offering a new operand set; it must be ignored until IDLE
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d", i),
                  64'({out_valid, in_ready, cout, ovf, sum}), {28'd0, 4'b1000, 32'h9999999A});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_not_taken_yet", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_taken", 64'(in_ready), 64'd0);
        exp = ref_add(32'hDEADBEEF, 32'h01010101, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp2_latency", 64'(lat), 64'(LAT));
        check("bp2_result", 64'({ovf, cout, sum}), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("[TB] bp second op sum=%08h cout=%0d ovf=%0d", sum, cout, ovf);

        // ---------------- reset mid-calculation ----------------
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_partial_sum", 64'(sum[11:0]), 64'h333);
        rst = 1'b1;
        #1;
        check("mid_rst_async", 64'({out_valid, in_ready, cout, ovf, sum}), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hold_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        $display("[TB] reset mid-calc discarded operation");
        run_op(32'd5, 32'd7, 1'b0, 0, "after_rst", rs, rc, ro);
        check("after_rst_const", 64'(rs), 64'h0000000C);

        // ---------------- randomized against model ----------------
        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                1: rb = ~ra;                     // long propagate chains
                2: ra = {1'b0, ra[30:0]};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i), rs, rc, ro);
        end

        // ---------------- single-slice instance ----------------
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            logic        rcin;
            if (i == 0) begin
                ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; rcin = 1'b1;
            end else begin
                ra = $urandom; rb = $urandom; rcin = 1'($urandom);
            end
            exp = ref_add(ra, rb, rcin);
            @(negedge clk);
            check($sformatf("n1_%0d_ready", i), 64'(in_ready1), 64'd1);
            a1 = ra; b1 = rb; cin1 = rcin; in_valid1 = 1'b1;
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            a1 = '0; b1 = '0;
            check($sformatf("n1_%0d_calc", i), 64'(out_valid1), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("n1_%0d_valid", i), 64'(out_valid1), 64'd1);
            check($sformatf("n1_%0d_result", i), 64'({ovf1, cout1, sum1}), 64'(exp));
            if (i == 0) begin
                check("n1_allones_const", 64'({ovf1, cout1, sum1}), {30'd0, 2'b01, 32'hFFFFFFFF});
            end
            $display("[TB] n1_%0d a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d ovf=%0d",
                     i, ra, rb, rcin, sum1, cout1, ovf1);
            out_ready1 = 1'b1;
            @(posedge clk);
            #1;
            out_ready1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
